// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave FSM states and a transfer-legality helper
// for the SRAM slave and its byte-lane decoder.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_e;

    // Sizes above a word, and half/word accesses off their natural boundary, are illegal.
    function automatic logic bad_align(input logic [2:0] size, input logic [1:0] a);
        return (size > HSIZE_WORD) ||
               ((size == HSIZE_HALF) && a[0]) ||
               ((size == HSIZE_WORD) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/ahb_byte_lane_dec.sv
// Little-endian byte-lane write strobes from transfer size and low address bits.
// Purely combinational; no flow control.
module ahb_byte_lane_dec (
    input  logic [2:0] hsize_i,
    input  logic [1:0] addr_i,
    output logic [3:0] strb_o
);
    import ahb_pkg::*;

    always_comb begin
        strb_o = 4'b0000;
        case (hsize_i)
            HSIZE_BYTE: strb_o = 4'b0001 << addr_i;
            HSIZE_HALF: strb_o = addr_i[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: strb_o = 4'b1111;
            default:    strb_o = 4'b0000;
        endcase
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: 2^ADDR_W bytes of 32-bit words, WAIT_STATES stall cycles per OKAY
// data phase, two-cycle ERROR response for out-of-range, oversized or misaligned transfers.
module ahb_sram_slave #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [1:0]  HTRANS,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);
    import ahb_pkg::*;

    localparam int         WORDS   = 2 ** (ADDR_W - 2);
    localparam logic [1:0] WS_LAST = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

    state_e              state_q, state_d;
    logic [1:0]          wcnt_q, wcnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [2:0]          size_q, size_d;
    logic                pend_q, pend_d;

    logic [31:0]         mem_q [WORDS];
    logic                accept;
    logic                req_err;
    logic                complete;
    logic [3:0]          strb;
    logic                unused_ahb;

    assign unused_ahb = ^{HBURST, HPROT};

    assign accept  = HSEL && HREADY &&
                     ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ)) &&
                     ((state_q == ST_IDLE) || (state_q == ST_ERR2));
    assign req_err = ((HADDR >> ADDR_W) != 32'd0) || bad_align(HSIZE, HADDR[1:0]);

    // pend_q marks a registered OKAY transfer whose data phase ends in the next IDLE cycle.
    assign complete = (state_q == ST_IDLE) && pend_q;

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        size_d    = size_q;
        pend_d    = pend_q;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;

        case (state_q)
            ST_IDLE, ST_ERR2: begin
                HRESP   = (state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
                pend_d  = 1'b0;
                state_d = ST_IDLE;
                if (accept) begin
                    addr_d  = HADDR[ADDR_W-1:0];
                    write_d = HWRITE;
                    size_d  = HSIZE;
                    if (req_err) begin
                        state_d = ST_ERR1;
                    end else begin
                        pend_d = 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_d = ST_WAIT;
                            wcnt_d  = 2'd0;
                        end
                    end
                end
            end
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                if (wcnt_q == WS_LAST) begin
                    state_d = ST_IDLE;
                    wcnt_d  = 2'd0;
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 2'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
            pend_q  <= pend_d;
        end
    end

    ahb_byte_lane_dec u_lane_dec (
        .hsize_i (size_q),
        .addr_i  (addr_q[1:0]),
        .strb_o  (strb)
    );

    // Storage is deliberately left out of reset; only the control path is cleared.
    always_ff @(posedge HCLK) begin
        if (complete && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) begin
                    mem_q[addr_q[ADDR_W-1:2]][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    assign HRDATA = (complete && !write_q) ? mem_q[addr_q[ADDR_W-1:2]] : 32'd0;

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the byte-address width; memory size is 2^ADDR_W bytes, organised as 32-bit words.
REQ-002 Parameter WAIT_STATES, default 1, legal range 0..3, SHALL set the number of HREADYOUT-low cycles inserted in every OKAY data phase.
REQ-003 HCLK  in  1  single clock; all state updates on its rising edge.
REQ-004 HRESETn  in  1  reset, asynchronous assert, active-low.
REQ-005 HSEL  in  1  slave select.
REQ-006 HADDR  in  32  byte address.
REQ-007 HWRITE  in  1  1 = write, 0 = read.
REQ-008 HSIZE  in  3  transfer size: 0 = byte, 1 = half-word, 2 = word.
REQ-009 HBURST  in  3  burst type; ignored.
REQ-010 HPROT  in  4  protection; ignored.
REQ-011 HTRANS  in  2  0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ.
REQ-012 HREADY  in  1  bus-level ready.
REQ-013 HWDATA  in  32  write data, valid in the data phase.
REQ-014 HRDATA  out  32  read data.
REQ-015 HREADYOUT  out  1  slave ready.
REQ-016 HRESP  out  1  0 = OKAY, 1 = ERROR.

Function
REQ-017 Acceptance rule: a transfer SHALL be accepted on an edge where HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ.
- On acceptance, HADDR, HWRITE and HSIZE SHALL be registered for the data phase.
REQ-018 IDLE or BUSY transfers, and cycles with HSEL=0, SHALL produce a zero-wait OKAY response.
REQ-019 FSM states SHALL be IDLE, WAIT, ERR1 and ERR2, with outputs:
- IDLE: HREADYOUT=1, HRESP=0.
- WAIT: HREADYOUT=0, HRESP=0.
- ERR1: HREADYOUT=0, HRESP=1.
- ERR2: HREADYOUT=1, HRESP=1.
REQ-020 Error condition: an accepted transfer SHALL be an error if any of the following holds:
- HADDR[31:ADDR_W] is nonzero;
- HSIZE > 2;
- HSIZE=1 with HADDR[0]=1;
- HSIZE=2 with HADDR[1:0] nonzero.
REQ-021 Transitions on each edge:
- Accepted error transfer -> ERR1, then unconditionally -> ERR2.
- Accepted OKAY transfer with WAIT_STATES>0 -> WAIT.
- Accepted OKAY transfer with WAIT_STATES=0 -> IDLE, with a one-cycle OKAY data phase.
- In IDLE or ERR2 with no acceptance -> IDLE.
REQ-022 Wait counter: WAIT SHALL hold for exactly WAIT_STATES cycles using a counter, then return to IDLE, which completes the data phase.
REQ-023 Acceptance in ERR2 or in the completing IDLE cycle SHALL be evaluated normally; this supports back-to-back pipelined transfers.
REQ-024 Write commit: a write SHALL update memory at the edge ending its data phase (HREADYOUT=1), using HWDATA sampled at that edge.
- Little-endian byte lanes SHALL be selected by HSIZE and HADDR[1:0].
- Unselected bytes SHALL be unchanged.
REQ-025 Read data: during the completing cycle of a read data phase, HRDATA SHALL carry the full word at address[ADDR_W-1:2]; in all other cycles HRDATA SHALL be 0.
REQ-026 Read-after-write: a read whose data phase immediately follows a write to the same word SHALL return the newly written data.
REQ-027 Errored transfers SHALL NOT modify memory, and SHALL return HRDATA=0.
REQ-028 Memory SHALL be a register array with combinational read.

Reset
REQ-029 While HRESETn=0, outputs SHALL be HREADYOUT=1, HRESP=0, HRDATA=0, with FSM=IDLE and the wait counter at 0.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer, discard any pending write and clear all registered address-phase fields.
REQ-031 Memory contents SHALL NOT be reset.

Structure
REQ-032 Package ahb_pkg SHALL hold the HTRANS and HSIZE encodings, the HRESP OKAY/ERROR constants and the FSM state enum.
REQ-033 Byte-lane write-enable generation SHALL be a sub-module named ahb_byte_lane_dec.
- Inputs: HSIZE, addr[1:0].
- Output: 4-bit strobe.

Verification
REQ-034 Word write/read, WAIT_STATES=1: write 0xDEADBEEF to 0x10, then read 0x10.
- Each data phase SHALL show 1 cycle of HREADYOUT=0.
- Read SHALL return HRDATA=0xDEADBEEF with HRESP=0.
REQ-035 Byte lanes: write byte 0xAA to 0x13 over a word of 0x00000000, then read 0x10 -> HRDATA=0xAA000000.
REQ-036 Out-of-range: write to 0x400 -> two-cycle ERROR (HREADYOUT 0 then 1, HRESP=1 in both cycles); memory SHALL be unchanged.
REQ-037 Unaligned: half-word read at 0x21 -> ERROR response with HRDATA=0.
REQ-038 Pipelined traffic, WAIT_STATES=0: back-to-back NONSEQ write 0x11223344 to 0x8, then read 0x8 -> read returns 0x11223344 with no stall cycles.
REQ-039 Reset mid-WAIT (WAIT_STATES=3): assert HRESETn low during the second wait cycle of a write.
- HREADYOUT SHALL go 1 immediately.
- Target word SHALL keep its old value.
